// File: rtl/alu_wb_stage_pkg.sv
// ----------------------------------------------------------------------------
// alu_wb_stage_pkg
// Shared constants and types for the ALU writeback/flag stage.
//   DATASIZE   : ALU datapath width (must match the codebase datasize define)
//   RADDR      : register-file address width (8 registers)
//   cond_e     : conditional-execution codes carried with each instruction
//   OP_ADD/NAND: ALU operation encoding
//   condPass() : resolves a condition code against the architectural flags
// ----------------------------------------------------------------------------
package alu_wb_stage_pkg;

    localparam int DATASIZE   = 16;
    localparam int RADDR      = 3;
    localparam int FIFO_WIDTH = DATASIZE + RADDR;

    typedef enum logic [1:0] {
        COND_AL = 2'b00,
        COND_Z  = 2'b01,
        COND_C  = 2'b10,
        COND_NV = 2'b11
    } cond_e;

    localparam logic OP_ADD  = 1'b1;
    localparam logic OP_NAND = 1'b0;

    // "Never" is an explicit no-op encoding, so it falls to the default.
    function automatic logic condPass(input cond_e cond, input logic flagC, input logic flagZ);
        logic pass;
        pass = 1'b0;
        case (cond)
            COND_AL: pass = 1'b1;
            COND_C:  pass = flagC;
            COND_Z:  pass = flagZ;
            default: pass = 1'b0;
        endcase
        return pass;
    endfunction

endpackage

// File: rtl/alu_wb_stage_if.sv
// ----------------------------------------------------------------------------
// alu_wb_stage_if
// Bundles the ALU-side input handshake, the register-file-side output
// handshake, flush, and the architectural flag outputs of alu_wb_stage.
//   slave  : the writeback stage itself
//   master : the environment (ALU / register file / control)
// ----------------------------------------------------------------------------
interface alu_wb_stage_if
    import alu_wb_stage_pkg::*;
#(
    parameter int DW = DATASIZE,
    parameter int AW = RADDR
);

    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_z;
    logic          in_carry;
    logic          in_zero;
    logic          in_op;
    logic [1:0]    in_cond;
    logic [AW-1:0] in_rd;
    logic          in_wen;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_rd;
    logic          flag_c;
    logic          flag_z;

    modport slave (
        input  in_valid, in_z, in_carry, in_zero, in_op, in_cond, in_rd, in_wen,
        input  flush, out_ready,
        output in_ready, out_valid, out_data, out_rd, flag_c, flag_z
    );

    modport master (
        output in_valid, in_z, in_carry, in_zero, in_op, in_cond, in_rd, in_wen,
        output flush, out_ready,
        input  in_ready, out_valid, out_data, out_rd, flag_c, flag_z
    );

endinterface

// File: rtl/alu_wb_stage_wb_fifo2.sv
// ----------------------------------------------------------------------------
// wb_fifo2
// Two-entry synchronous FIFO holding committed register writes.
//   clk, rst  : rising-edge clock, synchronous active-high reset
//   i_push    : write i_data at the tail (ignored when full)
//   i_pop     : drop the head entry (ignored when empty)
//   i_flush   : discard all entries
//   i_data    : entry to enqueue
//   o_data    : head entry; holds the last head value while empty
//   o_count   : number of entries held (0..2)
// ----------------------------------------------------------------------------
module wb_fifo2
    import alu_wb_stage_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic [1:0]       o_count
);

    logic [WIDTH-1:0] r_mem [0:1];
    logic [WIDTH-1:0] r_hold;
    logic             r_wrPtr;
    logic             r_rdPtr;
    logic [1:0]       r_count;
    logic             w_push;
    logic             w_pop;

    // Protect the storage against over/underflow even if a caller misbehaves.
    assign w_push = i_push & (r_count != 2'd2);
    assign w_pop  = i_pop  & (r_count != 2'd0);

    // Storage, 1-bit wrapping pointers and occupancy count. The hold register
    // tracks the current head every cycle the queue is non-empty, so once the
    // queue drains (by pop or flush) the last head stays on the output.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_hold   <= '0;
            r_wrPtr  <= 1'b0;
            r_rdPtr  <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (r_count != 2'd0) begin
                r_hold <= r_mem[r_rdPtr];
            end
            if (i_flush) begin
                r_wrPtr <= 1'b0;
                r_rdPtr <= 1'b0;
                r_count <= 2'd0;
            end else begin
                if (w_push) begin
                    r_mem[r_wrPtr] <= i_data;
                    r_wrPtr        <= ~r_wrPtr;
                end
                if (w_pop) begin
                    r_rdPtr <= ~r_rdPtr;
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + 2'd1;
                    2'b01:   r_count <= r_count - 2'd1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // Head is read straight from storage so an entry written at one edge is
    // visible in the following cycle.
    assign o_data  = (r_count != 2'd0) ? r_mem[r_rdPtr] : r_hold;
    assign o_count = r_count;

endmodule

// File: rtl/alu_wb_stage.sv
// ----------------------------------------------------------------------------
// alu_wb_stage
// Writeback/flag stage downstream of the ALU. Holds the architectural carry
// and zero flags, resolves conditional execution against them, and queues
// committed register writes (2 entries) toward the register-file write port.
//   clk, rst   : rising-edge clock, synchronous active-high reset
//   bus.in_*   : ALU result, carry/zero and decoded control; in_valid/in_ready
//   bus.flush  : discard queued entries and this cycle's input
//   bus.out_*  : head write data/address; out_valid/out_ready
//   bus.flag_c : architectural carry flag
//   bus.flag_z : architectural zero flag
// ----------------------------------------------------------------------------
module alu_wb_stage
    import alu_wb_stage_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    alu_wb_stage_if.slave bus
);

    logic                  r_flagC;
    logic                  r_flagZ;
    logic [1:0]            w_count;
    logic                  w_accept;
    logic                  w_exec;
    logic                  w_push;
    logic                  w_pop;
    logic [FIFO_WIDTH-1:0] w_head;

    // Readiness comes only from the registered occupancy, so there is no
    // combinational path from out_ready back to in_ready.
    assign bus.in_ready  = (w_count != 2'd2);
    assign bus.out_valid = (w_count != 2'd0);

    // The condition sees the flags as they stand before this instruction,
    // which already include the effect of the instruction accepted last cycle.
    assign w_accept = bus.in_valid & bus.in_ready & ~bus.flush;
    assign w_exec   = condPass(cond_e'(bus.in_cond), r_flagC, r_flagZ);
    assign w_push   = w_accept & w_exec & bus.in_wen;
    assign w_pop    = bus.out_valid & bus.out_ready;

    // Architectural flags: add writes both, nand writes only zero; skipped
    // or flushed instructions leave both untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_flagC <= 1'b0;
            r_flagZ <= 1'b0;
        end else if (w_accept && w_exec) begin
            r_flagZ <= bus.in_zero;
            if (bus.in_op == OP_ADD) begin
                r_flagC <= bus.in_carry;
            end
        end
    end

    wb_fifo2 #(
        .WIDTH (FIFO_WIDTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (bus.flush),
        .i_data  ({bus.in_z, bus.in_rd}),
        .o_data  (w_head),
        .o_count (w_count)
    );

    assign bus.out_data = w_head[FIFO_WIDTH-1:RADDR];
    assign bus.out_rd   = w_head[RADDR-1:0];
    assign bus.flag_c   = r_flagC;
    assign bus.flag_z   = r_flagZ;

endmodule

// File: tb/tb_alu_wb_stage.sv
// ----------------------------------------------------------------------------
// tb_alu_wb_stage
// Self-checking bench for alu_wb_stage. A queue-based reference model of the
// stage (flags plus list of pending writes) is advanced once per clock and
// compared against the DUT; directed scenarios also check fixed values.
// ----------------------------------------------------------------------------
module tb_alu_wb_stage;
    import alu_wb_stage_pkg::*;

    localparam int W  = DATASIZE + RADDR;
    localparam int VW = 4 + W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    alu_wb_stage_if bus ();

    alu_wb_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    // Reference model: pending writes in order, flags, last head shown.
    logic [W-1:0] mq[$];
    logic         mc = 1'b0;
    logic         mz = 1'b0;
    logic [W-1:0] mshow = '0;

    // Safety net so a stuck run still ends with a visible failure.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [VW-1:0] modelVec();
        logic [W-1:0] h;
        h = (mq.size() != 0) ? mq[0] : mshow;
        return {(mq.size() != 0), (mq.size() < 2), mc, mz, h};
    endfunction

    function automatic logic [VW-1:0] dutVec();
        return {bus.out_valid, bus.in_ready, bus.flag_c, bus.flag_z, bus.out_data, bus.out_rd};
    endfunction

    task automatic applyStimulus(input logic valid, input logic [DATASIZE-1:0] z,
                                 input logic carry, input logic zero, input logic op,
                                 input logic [1:0] cond, input logic [RADDR-1:0] rd,
                                 input logic wen);
        bus.in_valid = valid;
        bus.in_z     = z;
        bus.in_carry = carry;
        bus.in_zero  = zero;
        bus.in_op    = op;
        bus.in_cond  = cond;
        bus.in_rd    = rd;
        bus.in_wen   = wen;
    endtask

    // Advance one clock: the model applies the stage's rules to the inputs
    // present at the edge, then outputs are sampled 1 unit after the edge.
    task automatic step(output bit accepted);
        bit macc;
        bit mex;
        bit mpop;
        macc = bus.in_valid && (mq.size() < 2) && !bus.flush;
        mex  = (bus.in_cond == 2'b00) || (bus.in_cond == 2'b10 && mc) ||
               (bus.in_cond == 2'b01 && mz);
        mpop = (mq.size() != 0) && bus.out_ready;
        if (mq.size() != 0) mshow = mq[0];
        @(posedge clk);
        if (rst) begin
            mq.delete();
            mc    = 1'b0;
            mz    = 1'b0;
            mshow = '0;
            macc  = 1'b0;
        end else begin
            if (mpop) void'(mq.pop_front());
            if (bus.flush) begin
                mq.delete();
            end else if (macc && mex) begin
                mz = bus.in_zero;
                if (bus.in_op) mc = bus.in_carry;
                if (bus.in_wen) mq.push_back({bus.in_z, bus.in_rd});
            end
        end
        accepted = macc;
        #1;
    endtask

    task automatic tick();
        bit unused;
        step(unused);
    endtask

    task automatic idle();
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 2'b00, '0, 1'b0);
    endtask

    task automatic test_reset();
        idle();
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if (dutVec() !== {1'b0, 1'b1, 1'b0, 1'b0, {W{1'b0}}}) begin
            errors++;
            $display("[TB] FAIL reset_state got %h want %h", dutVec(), {1'b0, 1'b1, 1'b0, 1'b0, {W{1'b0}}});
        end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (bus.out_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL idle_out_valid cycle %0d got %b want 0", i, bus.out_valid);
            end
        end
    endtask

    task automatic test_basic_add();
        bus.out_ready = 1'b1;
        applyStimulus(1'b1, 16'h0000, 1'b1, 1'b1, OP_ADD, 2'b00, 3'd3, 1'b1);
        tick();
        idle();
        checks++;
        if ({bus.out_valid, bus.out_data, bus.out_rd, bus.flag_c, bus.flag_z} !== {1'b1, 16'h0000, 3'd3, 1'b1, 1'b1}) begin
            errors++;
            $display("[TB] FAIL basic_add got v=%b d=%h rd=%0d c=%b z=%b want v=1 d=0000 rd=3 c=1 z=1",
                     bus.out_valid, bus.out_data, bus.out_rd, bus.flag_c, bus.flag_z);
        end
        tick();
        checks++;
        if ({bus.out_valid, bus.out_rd} !== {1'b0, 3'd3}) begin
            errors++;
            $display("[TB] FAIL basic_drain_hold got v=%b rd=%0d want v=0 rd=3", bus.out_valid, bus.out_rd);
        end
    endtask

    task automatic test_cond_c();
        bus.out_ready = 1'b0;
        applyStimulus(1'b1, 16'h0000, 1'b0, 1'b0, OP_ADD, 2'b00, 3'd0, 1'b0);
        tick();
        applyStimulus(1'b1, 16'h1234, 1'b1, 1'b1, OP_ADD, 2'b10, 3'd2, 1'b1);
        tick();
        checks++;
        if ({bus.out_valid, bus.flag_c, bus.flag_z} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL cond_c_skip got v=%b c=%b z=%b want 000", bus.out_valid, bus.flag_c, bus.flag_z);
        end
        applyStimulus(1'b1, 16'h5555, 1'b1, 1'b0, OP_ADD, 2'b00, 3'd1, 1'b1);
        tick();
        applyStimulus(1'b1, 16'h00AA, 1'b0, 1'b0, OP_ADD, 2'b10, 3'd5, 1'b1);
        tick();
        idle();
        checks++;
        if ({bus.in_ready, bus.flag_c, bus.out_data, bus.out_rd} !== {1'b0, 1'b0, 16'h5555, 3'd1}) begin
            errors++;
            $display("[TB] FAIL cond_c_first got rdy=%b c=%b d=%h rd=%0d want rdy=0 c=0 d=5555 rd=1",
                     bus.in_ready, bus.flag_c, bus.out_data, bus.out_rd);
        end
        bus.out_ready = 1'b1;
        tick();
        checks++;
        if ({bus.out_valid, bus.out_data, bus.out_rd} !== {1'b1, 16'h00AA, 3'd5}) begin
            errors++;
            $display("[TB] FAIL cond_c_second got v=%b d=%h rd=%0d want v=1 d=00aa rd=5",
                     bus.out_valid, bus.out_data, bus.out_rd);
        end
        tick();
        checks++;
        if (dutVec() !== modelVec()) begin
            errors++;
            $display("[TB] FAIL cond_c_model got %h want %h", dutVec(), modelVec());
        end
    endtask

    task automatic test_nand_nv();
        bus.out_ready = 1'b1;
        applyStimulus(1'b1, 16'h0000, 1'b1, 1'b1, OP_ADD, 2'b00, 3'd0, 1'b0);
        tick();
        applyStimulus(1'b1, 16'hFFFF, 1'b0, 1'b0, OP_NAND, 2'b00, 3'd4, 1'b0);
        tick();
        checks++;
        if ({bus.flag_c, bus.flag_z} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL nand_flags got c=%b z=%b want c=1 z=0", bus.flag_c, bus.flag_z);
        end
        applyStimulus(1'b1, 16'h7777, 1'b0, 1'b1, OP_ADD, 2'b11, 3'd6, 1'b1);
        tick();
        idle();
        checks++;
        if ({bus.out_valid, bus.flag_c, bus.flag_z} !== 3'b010) begin
            errors++;
            $display("[TB] FAIL never_noop got v=%b c=%b z=%b want v=0 c=1 z=0", bus.out_valid, bus.flag_c, bus.flag_z);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] want [3];
        logic [W-1:0] got[$];
        bit           acc;
        int           cyc;
        want[0] = {16'h1111, 3'd1};
        want[1] = {16'h2222, 3'd2};
        want[2] = {16'h3333, 3'd3};
        bus.out_ready = 1'b0;
        applyStimulus(1'b1, 16'h1111, 1'b0, 1'b0, OP_ADD, 2'b00, 3'd1, 1'b1);
        step(acc);
        applyStimulus(1'b1, 16'h2222, 1'b0, 1'b0, OP_ADD, 2'b00, 3'd2, 1'b1);
        step(acc);
        applyStimulus(1'b1, 16'h3333, 1'b0, 1'b0, OP_ADD, 2'b00, 3'd3, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(acc);
            checks++;
            if ({bus.in_ready, bus.out_valid} !== 2'b01) begin
                errors++;
                $display("[TB] FAIL b2b_full cycle %0d got rdy=%b v=%b want rdy=0 v=1", i, bus.in_ready, bus.out_valid);
            end
        end
        bus.out_ready = 1'b1;
        cyc = 0;
        while (got.size() < 3 && cyc < 20) begin
            if (bus.out_valid && bus.out_ready) got.push_back({bus.out_data, bus.out_rd});
            step(acc);
            if (acc) idle();
            cyc++;
        end
        idle();
        checks++;
        if (got.size() != 3) begin
            errors++;
            $display("[TB] FAIL b2b_count got %0d want 3", got.size());
        end
        for (int i = 0; i < 3; i++) begin
            if (i < got.size()) begin
                checks++;
                if (got[i] !== want[i]) begin
                    errors++;
                    $display("[TB] FAIL b2b_order entry %0d got %h want %h", i, got[i], want[i]);
                end
            end
        end
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_no_dup got v=%b want 0", bus.out_valid);
        end
    endtask

    task automatic test_flush();
        bus.out_ready = 1'b0;
        applyStimulus(1'b1, 16'hAAAA, 1'b1, 1'b0, OP_ADD, 2'b00, 3'd1, 1'b1);
        tick();
        applyStimulus(1'b1, 16'hBBBB, 1'b1, 1'b0, OP_ADD, 2'b00, 3'd2, 1'b1);
        tick();
        applyStimulus(1'b1, 16'h9999, 1'b0, 1'b1, OP_ADD, 2'b00, 3'd7, 1'b1);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        idle();
        checks++;
        if ({bus.out_valid, bus.in_ready, bus.flag_c, bus.flag_z, bus.out_data} !== {4'b0110, 16'hAAAA}) begin
            errors++;
            $display("[TB] FAIL flush got v=%b rdy=%b c=%b z=%b d=%h want v=0 rdy=1 c=1 z=0 d=aaaa",
                     bus.out_valid, bus.in_ready, bus.flag_c, bus.flag_z, bus.out_data);
        end
        applyStimulus(1'b1, 16'hCCCC, 1'b0, 1'b1, OP_ADD, 2'b00, 3'd4, 1'b1);
        tick();
        applyStimulus(1'b1, 16'hDDDD, 1'b1, 1'b1, OP_ADD, 2'b00, 3'd5, 1'b1);
        tick();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (dutVec() !== {1'b0, 1'b1, 1'b0, 1'b0, {W{1'b0}}}) begin
            errors++;
            $display("[TB] FAIL reset_full got %h want %h", dutVec(), {1'b0, 1'b1, 1'b0, 1'b0, {W{1'b0}}});
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, 16'($urandom), 1'($urandom), 1'($urandom),
                          1'($urandom), 2'($urandom), 3'($urandom), $urandom_range(0, 4) != 0);
            bus.flush     = ($urandom_range(0, 19) == 0);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            rst           = ($urandom_range(0, 149) == 0);
            tick();
            checks++;
            if (dutVec() !== modelVec()) begin
                errors++;
                $display("[TB] FAIL random cycle %0d got %h want %h", i, dutVec(), modelVec());
            end
        end
        rst       = 1'b0;
        bus.flush = 1'b0;
        idle();
    endtask

    initial begin
        idle();
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_basic_add();
        test_cond_c();
        test_nand_nv();
        test_back_to_back();
        test_flush();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_wb_stage.md
Name: alu_wb_stage

Overview:
- Writeback/flag stage directly downstream of the ALU.
- Consumes the ALU result and its carry/zero outputs together with the instruction's decoded control fields.
- Holds the architectural carry and zero flags and resolves conditional execution (add/nand if C, add/nand if Z) against them.
- Buffers committed register writes in a 2-entry queue toward the register-file write port, using a valid/ready handshake on both sides.

Parameters:
- DATASIZE, 16, ALU datapath width; must equal the codebase datasize define.
- RADDR, 3, register-file address width (8 registers).

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  ALU result plus control presented
- in_ready  out  1  stage can accept; high when fewer than 2 entries are queued
- in_z  in  DATASIZE  ALU result
- in_carry  in  1  ALU carry output
- in_zero  in  1  ALU zero output
- in_op  in  1  ALU op: 1 = add, 0 = nand
- in_cond  in  2  00 always, 10 if C, 01 if Z, 11 never (no-op)
- in_rd  in  RADDR  destination register
- in_wen  in  1  instruction writes a register
- flush  in  1  discard queued entries and any input this cycle
- out_valid  out  1  head entry available
- out_ready  in  1  register file accepts head
- out_data  out  DATASIZE  head write data
- out_rd  out  RADDR  head write address
- flag_c  out  1  architectural carry flag
- flag_z  out  1  architectural zero flag

Behaviour:
- Reset (rst high at clk edge):
  - queue count = 0, out_valid = 0, out_data = 0, out_rd = 0, flag_c = 0, flag_z = 0.
  - in_ready is high in the cycle after reset.
  - Reset overrides flush and all traffic; reset mid-stream drops all entries.
- Accept: acc = in_valid & in_ready & ~flush. Input fields are don't-care when acc = 0.
- Condition, evaluated against the current flag_c/flag_z registers (pre-update value):
  - exec = (cond==00) | (cond==10 & flag_c) | (cond==01 & flag_z).
  - cond 11 gives exec = 0.
- Flag update on acc & exec, visible the next cycle:
  - op=1: flag_c <= in_carry, flag_z <= in_zero.
  - op=0: flag_z <= in_zero, flag_c unchanged.
  - No flag change when exec = 0.
- Enqueue on acc & exec & in_wen: {in_z, in_rd} is pushed at the tail.
  - An instruction with exec = 0, or with wen = 0, is still consumed but produces no entry.
- Ordering: back-to-back accepts in cycles N and N+1 see each other's flags in order. The instruction at N+1 evaluates its condition against the flags written by N.
- Latency:
  - An entry enqueued at edge N is visible (out_valid = 1) from cycle N+1.
  - No combinational path from in_* to out_*.
- Dequeue on out_valid & out_ready; the next entry moves to head the following cycle.
- Simultaneous push and pop with count = 1: count stays 1, the new entry becomes head.
- Simultaneous push and pop with count = 2: cannot occur, because in_ready = 0 when full.
- in_ready is registered-count based (count < 2) and does not depend on out_ready combinationally.
- Flush:
  - count <= 0 next cycle; the input in the same cycle is not accepted and has no flag effect.
  - Flags already committed are kept.
  - A pop in the flush cycle still completes if out_valid & out_ready.
- out_data/out_rd hold their last value when out_valid = 0 (not re-zeroed except by reset).
- Queue pointers wrap modulo 2 (1-bit rd/wr pointers, 2-bit count).

Decomposition:
- Shared package/define file:
  - DATASIZE/RADDR constants.
  - Condition-code constants: COND_AL = 2'b00, COND_Z = 2'b01, COND_C = 2'b10, COND_NV = 2'b11.
  - ALU op constants: OP_ADD = 1, OP_NAND = 0.
- One natural sub-module: wb_fifo2, a 2-entry synchronous FIFO of width DATASIZE+RADDR with push/pop/flush/count. The top level holds the flag registers and condition logic.

Test Plan:
- Reset, then idle → out_valid = 0, flag_c = 0, flag_z = 0, in_ready = 1; hold out_ready = 1 for 10 cycles and no output appears.
- Add with z=16'h0000, carry=1, zero=1, cond=00, rd=3, wen=1 → one cycle later out_valid = 1, out_data = 0, out_rd = 3, flag_c = 1, flag_z = 1.
- From flag_c = 0: cond=10 add (z=16'h1234, rd=2), then cond=00 add with carry=1, then cond=10 add (z=16'h00AA, rd=5) → first is dropped; second is written; third is written with out_data = 16'h00AA, out_rd = 5.
- Nand with zero=0 while flag_c = 1, flag_z = 1 → flag_z = 0, flag_c stays 1; cond=11 instruction → no entry, flags unchanged.
- out_ready = 0 and three back-to-back valid adds → in_ready falls after two accepts; third is held until out_ready = 1; outputs arrive in order with no loss or duplication.
- Two entries queued plus flush asserted with a new valid input → next cycle out_valid = 0, count = 0; the flushed input leaves flags unchanged. Also assert rst while full → all outputs return to reset values next cycle.
